// File: rtl/uc_pkg.sv
// Shared opcodes, state encoding, mux-select encodings and control word for the
// multi-cycle MIPS control unit. ILLEGAL_OP_TRAP_EN adds the illegal-opcode flag.
package uc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ITYPE = 6'b000001;
  localparam logic [5:0] OP_LWI   = 6'b100011;
  localparam logic [5:0] OP_LW    = 6'b100010;
  localparam logic [5:0] OP_SW    = 6'b101010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000110;
  localparam logic [5:0] OP_J     = 6'b010000;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC    = 4'd2,
    S_ALU_WB  = 4'd3,
    S_ADDR    = 4'd4,
    S_MEM_RD  = 4'd5,
    S_LOAD_WB = 4'd6,
    S_MEM_WR  = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_TRAP    = 4'd10
  } state_t;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_IMM   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_LOAD  = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       memto_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
`ifdef ILLEGAL_OP_TRAP_EN
    logic       illegal_op;
`endif
  } ctrl_t;

endpackage

// File: rtl/uc_mc_saida.sv
// Combinational control-word decoder: current state + opcode (+ memAck in FETCH)
// to datapath selects. TRAP handling exists only with ILLEGAL_OP_TRAP_EN.
module uc_mc_saida
  import uc_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       mem_ack,
  output ctrl_t      ctrl
);

  always_comb begin
    // NOTE: every field gets a default first so no path leaves a latch behind.
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        if (mem_ack) begin
          ctrl.ir_write  = 1'b1;
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PCSRC_ALU;
        end
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = (opcode == OP_RTYPE) ? SRCB_REG : SRCB_IMM;
        ctrl.alu_op    = (opcode == OP_LWI) ? ALUOP_IMM : ALUOP_FUNCT;
      end
      S_ALU_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = (opcode != OP_LWI);
      end
      S_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = (opcode == OP_LW) ? ALUOP_LOAD : ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_LOAD_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.memto_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.branch_ne     = (opcode == OP_BNE);
        ctrl.alu_op        = (opcode == OP_BNE) ? ALUOP_FUNCT : ALUOP_ADD;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP: ctrl.illegal_op = 1'b1;
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/unidade_de_controle_multiciclo.sv
// Multi-cycle MIPS control FSM with retired-instruction counter.
// Define ILLEGAL_OP_TRAP_EN to trap unknown opcodes instead of treating them as NOPs.
module unidade_de_controle_multiciclo
  import uc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       instrucao,
  input  logic             memAck,
  output logic             pcWrite,
  output logic             pcWriteCond,
  output logic             branchNe,
  output logic [1:0]       pcSource,
  output logic             iorD,
  output logic             memRead,
  output logic             memWrite,
  output logic             irWrite,
  output logic             regDst,
  output logic             memtoReg,
  output logic             regWrite,
  output logic             aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       aluOp,
`ifdef ILLEGAL_OP_TRAP_EN
  output logic             illegalOp,
`endif
  output logic [CNT_W-1:0] instrCount
);

  state_t state, state_next;
  ctrl_t  ctrl, ctrl_out;
  logic   retire;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_FETCH:  if (memAck) state_next = S_DECODE;
      S_DECODE: begin
        unique case (instrucao)
          OP_RTYPE, OP_ITYPE, OP_LWI: state_next = S_EXEC;
          OP_LW, OP_SW:               state_next = S_ADDR;
          OP_BEQ, OP_BNE:             state_next = S_BRANCH;
          OP_J:                       state_next = S_JUMP;
`ifdef ILLEGAL_OP_TRAP_EN
          default:                    state_next = S_TRAP;
`else
          default:                    state_next = S_FETCH;
`endif
        endcase
      end
      S_EXEC:    state_next = S_ALU_WB;
      S_ALU_WB:  state_next = S_FETCH;
      S_ADDR:    state_next = (instrucao == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  if (memAck) state_next = S_LOAD_WB;
      S_LOAD_WB: state_next = S_FETCH;
      S_MEM_WR:  if (memAck) state_next = S_FETCH;
      S_BRANCH:  state_next = S_FETCH;
      S_JUMP:    state_next = S_FETCH;
      S_TRAP:    state_next = S_TRAP;
      default:   state_next = S_FETCH;
    endcase
  end

  // An instruction retires on the cycle the FSM heads back to FETCH.
  assign retire = (state != S_FETCH) && (state_next == S_FETCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         instrCount <= '0;
    else if (retire) instrCount <= instrCount + 1'b1;
  end

  uc_mc_saida u_saida (
    .state   (state),
    .opcode  (instrucao),
    .mem_ack (memAck),
    .ctrl    (ctrl)
  );

  // Reset must silence the memory request at once, even though FETCH drives memRead.
  assign ctrl_out    = rst ? '0 : ctrl;

  assign pcWrite     = ctrl_out.pc_write;
  assign pcWriteCond = ctrl_out.pc_write_cond;
  assign branchNe    = ctrl_out.branch_ne;
  assign pcSource    = ctrl_out.pc_source;
  assign iorD        = ctrl_out.iord;
  assign memRead     = ctrl_out.mem_read;
  assign memWrite    = ctrl_out.mem_write;
  assign irWrite     = ctrl_out.ir_write;
  assign regDst      = ctrl_out.reg_dst;
  assign memtoReg    = ctrl_out.memto_reg;
  assign regWrite    = ctrl_out.reg_write;
  assign aluSrcA     = ctrl_out.alu_src_a;
  assign aluSrcB     = ctrl_out.alu_src_b;
  assign aluOp       = ctrl_out.alu_op;
`ifdef ILLEGAL_OP_TRAP_EN
  assign illegalOp   = ctrl_out.illegal_op;
`endif

endmodule

// File: tb/tb_unidade_de_controle_multiciclo.sv
// Self-checking bench: instruction-level reference model of the multi-cycle control
// unit, directed cases plus randomized opcodes and memory wait states.
module tb_unidade_de_controle_multiciclo;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic [5:0] instrucao;
  logic memAck;
  logic pcWrite, pcWriteCond, branchNe, iorD, memRead, memWrite, irWrite;
  logic regDst, memtoReg, regWrite, aluSrcA;
  logic [1:0] pcSource, aluSrcB, aluOp;
  logic [CNT_W-1:0] instrCount;
`ifdef ILLEGAL_OP_TRAP_EN
  logic illegalOp;
`endif

  unidade_de_controle_multiciclo #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .instrucao(instrucao), .memAck(memAck),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .branchNe(branchNe),
    .pcSource(pcSource), .iorD(iorD), .memRead(memRead), .memWrite(memWrite),
    .irWrite(irWrite), .regDst(regDst), .memtoReg(memtoReg), .regWrite(regWrite),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
`ifdef ILLEGAL_OP_TRAP_EN
    .illegalOp(illegalOp),
`endif
    .instrCount(instrCount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write, pc_write_cond, branch_ne;
    logic [1:0] pc_source;
    logic       iord, mem_read, mem_write, ir_write, reg_dst, memto_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
  } ctl_t;

  ctl_t obs;
  assign obs = {pcWrite, pcWriteCond, branchNe, pcSource, iorD, memRead, memWrite,
                irWrite, regDst, memtoReg, regWrite, aluSrcA, aluSrcB, aluOp};

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] model_cnt;
  logic [5:0] legal_ops [8] = '{6'b000000, 6'b000001, 6'b100011, 6'b100010,
                                6'b101010, 6'b000100, 6'b000110, 6'b010000};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic string op_class(input logic [5:0] op);
    case (op)
      6'b000000: return "R";
      6'b000001: return "I";
      6'b100011: return "LWI";
      6'b100010: return "LW";
      6'b101010: return "SW";
      6'b000100: return "BEQ";
      6'b000110: return "BNE";
      6'b010000: return "J";
      default:   return "ILL";
    endcase
  endfunction

  // Expected control word for one phase of an instruction, straight from the phase table.
  function automatic ctl_t model(input string ph, input logic [5:0] op, input logic ack);
    ctl_t e;
    string c;
    e = '0;
    c = op_class(op);
    case (ph)
      "FETCH": begin
        e.mem_read = 1; e.alu_src_b = 2'b01;
        if (ack) begin e.ir_write = 1; e.pc_write = 1; end
      end
      "DECODE":  e.alu_src_b = 2'b11;
      "EXEC": begin
        e.alu_src_a = 1;
        e.alu_src_b = (c == "R") ? 2'b00 : 2'b10;
        e.alu_op    = (c == "LWI") ? 2'b01 : 2'b10;
      end
      "ALU_WB":  begin e.reg_write = 1; e.reg_dst = (c != "LWI"); end
      "ADDR": begin
        e.alu_src_a = 1; e.alu_src_b = 2'b10;
        e.alu_op = (c == "LW") ? 2'b11 : 2'b00;
      end
      "MEM_RD":  begin e.iord = 1; e.mem_read = 1; end
      "LOAD_WB": begin e.reg_write = 1; e.memto_reg = 1; end
      "MEM_WR":  begin e.iord = 1; e.mem_write = 1; end
      "BRANCH": begin
        e.alu_src_a = 1; e.pc_write_cond = 1; e.pc_source = 2'b01;
        e.branch_ne = (c == "BNE");
        e.alu_op    = (c == "BNE") ? 2'b10 : 2'b00;
      end
      "JUMP":    begin e.pc_write = 1; e.pc_source = 2'b10; end
      default:   e = '0;
    endcase
    return e;
  endfunction

  // One clock cycle: drive inputs on the falling edge, compare just after.
  task automatic step(input string ph, input logic [5:0] op, input logic ack);
    @(negedge clk);
    memAck = ack;
    #1;
    check($sformatf("%s op=%b", ph, op), obs, model(ph, op, ack));
`ifdef ILLEGAL_OP_TRAP_EN
    check($sformatf("illegalOp %s", ph), illegalOp, 1'b0);
`endif
  endtask

  task automatic do_reset_check();
    rst = 1'b1;
    #1;
    check("reset ctrl", obs, 32'd0);
    check("reset count", instrCount, 32'd0);
`ifdef ILLEGAL_OP_TRAP_EN
    check("reset illegalOp", illegalOp, 1'b0);
`endif
    model_cnt = '0;
    rst = 1'b0;
  endtask

  task automatic wait_mem(input string ph, input logic [5:0] op, input int waits);
    for (int k = 0; k <= waits; k++) step(ph, op, k == waits);
  endtask

  task automatic run_instr(input logic [5:0] op, input int fetch_wait, input int mem_wait);
    string c;
    bit retired;
    c = op_class(op);
    retired = 1;
    for (int k = 0; k <= fetch_wait; k++) begin
      @(negedge clk);
      memAck = (k == fetch_wait);
      instrucao = (k == fetch_wait) ? op : 6'($urandom_range(0, 63));
      #1;
      check($sformatf("FETCH op=%b", op), obs, model("FETCH", op, memAck));
    end
    step("DECODE", op, 1'($urandom_range(0, 1)));
    case (c)
      "R", "I", "LWI": begin
        step("EXEC", op, 1'($urandom_range(0, 1)));
        step("ALU_WB", op, 1'($urandom_range(0, 1)));
      end
      "LW": begin
        step("ADDR", op, 1'($urandom_range(0, 1)));
        wait_mem("MEM_RD", op, mem_wait);
        step("LOAD_WB", op, 1'($urandom_range(0, 1)));
      end
      "SW": begin
        step("ADDR", op, 1'($urandom_range(0, 1)));
        wait_mem("MEM_WR", op, mem_wait);
      end
      "BEQ", "BNE": step("BRANCH", op, 1'($urandom_range(0, 1)));
      "J":          step("JUMP", op, 1'($urandom_range(0, 1)));
      default: begin
`ifdef ILLEGAL_OP_TRAP_EN
        retired = 0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          memAck = 1'($urandom_range(0, 1));
          #1;
          check("TRAP ctrl", obs, 32'd0);
          check("TRAP illegalOp", illegalOp, 1'b1);
          check("TRAP count", instrCount, 32'(model_cnt));
        end
        do_reset_check();
`endif
      end
    endcase
    if (retired) begin
      model_cnt = model_cnt + 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("instrCount after %s", c), instrCount, 32'(model_cnt));
    end
  endtask

  initial begin
    rst = 1'b1;
    memAck = 1'b0;
    instrucao = 6'd0;
    model_cnt = '0;
    #1;
    check("reset ctrl", obs, 32'd0);
    check("reset count", instrCount, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed cases: each class once, then the 3-cycle delayed load and the unknown opcode.
    run_instr(6'b000000, 0, 0);
    run_instr(6'b100010, 0, 3);
    run_instr(6'b101010, 0, 0);
    run_instr(6'b000110, 0, 0);
    run_instr(6'b010000, 0, 0);
    run_instr(6'b000100, 1, 0);
    run_instr(6'b000001, 0, 0);
    run_instr(6'b100011, 2, 0);
    run_instr(6'b111111, 0, 0);

    // Reset in the middle of a stalled load.
    for (int k = 0; k < 1; k++) begin
      step("FETCH", 6'b100010, 1'b0);
      @(negedge clk); memAck = 1'b1; instrucao = 6'b100010; #1;
      check("FETCH pre-rst", obs, model("FETCH", 6'b100010, 1'b1));
      step("DECODE", 6'b100010, 1'b0);
      step("ADDR", 6'b100010, 1'b0);
      step("MEM_RD", 6'b100010, 1'b0);
      step("MEM_RD", 6'b100010, 1'b0);
      do_reset_check();
    end
    run_instr(6'b000000, 0, 0);

    // Randomized stream; the 4-bit counter wraps several times.
    for (int n = 0; n < 60; n++) begin
      logic [5:0] op;
      int sel;
      sel = $urandom_range(0, 9);
      op = (sel < 8) ? legal_ops[sel] : 6'($urandom_range(0, 63));
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
